audio_interp_dither: RTL and testbench
======================================

// Module: audio_interp_dither
// PURPOSE
//  Audio conditioning stage between the I2S clock-domain crossing and fm_modulator, in the clk domain.
//  Linearly interpolates each new A-bit sample over 2^R clk cycles, removing staircase steps from the deviation.
//  Optionally adds LFSR dither scaled by dith_fact, then rounds and saturates back to A bits.
//  Output feeds fm_modulator.audio directly.
// PARAMETERS
//  A        8       audio width, two's complement, in and out
//  R        10      log2 of ramp length in clk cycles (1024 clk at 50 MHz, about one 48 kHz sample period)
//  SEED     16'hACE1  LFSR reset value; must be non-zero
// PORTS
//  clk        in   1   system clock (50 MHz)
//  rst        in   1   synchronous reset, active-high
//  audio_in   in   A   new sample, signed; valid only while audio_stb=1
//  audio_stb  in   1   one-cycle strobe: a new sample is present on audio_in
//  interp_ena in   1   1: ramp between samples; 0: step to each new sample immediately
//  dith_fact  in   3   dither amplitude; 0 = off, 7 = max (+/-1 output LSB)
//  audio_out  out  A   conditioned signed audio to fm_modulator, registered
//  clip       out  1   1-cycle pulse when saturation limited audio_out
// BEHAVIOUR
//  Registers: cur[A] (last target), delta[A+1] signed, acc[A+R] signed (fixed point, R fraction bits),
//    cnt[R], ramping, lfsr[16], audio_out, clip.
//  Reset: all registers 0, ramping=0, lfsr=SEED, audio_out=0, clip=0. Reset overrides every other input.
//  States: IDLE (ramping=0, acc holds cur<<R) and RAMP (ramping=1).
//  audio_stb=1 and interp_ena=1: acc<=cur<<R; delta<=audio_in-cur; cur<=audio_in; cnt<=0; ramping<=1.
//  audio_stb=1 and interp_ena=0: acc<=audio_in<<R; cur<=audio_in; ramping<=0.
//  RAMP with no strobe: acc<=acc+delta and cnt<=cnt+1 each clk.
//    When cnt==2^R-1, ramping<=0. After exactly 2^R adds, acc==cur<<R exactly.
//  Strobe during RAMP: the new strobe wins. acc snaps to the old target cur<<R and a fresh ramp starts.
//    This discontinuity is intended.
//  interp_ena falling during RAMP: acc<=cur<<R next clk, ramping<=0.
//  LFSR: Galois, taps 16'hB400, shifts every clk regardless of other inputs.
//  Dither d: the signed (R+1)-bit value lfsr[R:0], range -2^R..2^R-1.
//    It is arithmetically shifted right by (7-dith_fact). When dith_fact=0, d=0.
//  Output path (1 register, combinational from acc and lfsr):
//    sum = acc + d + 2^(R-1), in A+R+2 bits.
//    q = sum >>> R, i.e. round half-up.
//    If q > 2^(A-1)-1: audio_out<=2^(A-1)-1 and clip<=1.
//    Else if q < -2^(A-1): audio_out<=-2^(A-1) and clip<=1.
//    Else: audio_out<=q and clip<=0.
//  Latency: a strobe sampled at edge t updates acc at t. With interp_ena=0 and dith_fact=0,
//    audio_out==audio_in after edge t+1 (2 clk from strobe assertion).
//  Never wraps: all internal widths carry one guard bit, and only the final stage saturates.
//  No back-pressure: audio_stb is accepted every cycle it is high, including back-to-back cycles.
// TESTING
//  1. Assert rst for 2 clk -> audio_out=0, clip=0, lfsr=16'hACE1. Check with and without a concurrent strobe.
//  2. interp_ena=0, dith_fact=0, strobe 8'h40 -> audio_out=8'h40 exactly 2 clk after the strobe, then stable.
//  3. interp_ena=1, dith 0, cur=0, strobe 8'h40 -> audio_out=8'h20 at ramp cycle 512 and 8'h40 from cycle 1024 on.
//     Output must be monotonic non-decreasing throughout.
//  4. Mid-ramp (cnt=300) strobe 8'hC0 -> audio_out jumps to 8'h40, then ramps down to 8'hC0 over 1024 clk.
//  5. cur=8'h7F, dith_fact=7 for 4096 clk -> audio_out is only ever 8'h7E or 8'h7F (never 8'h80) and clip pulses occur.
//     Repeat with cur=8'h80: never 8'h7F.
//  6. rst asserted mid-ramp -> next clk audio_out=0, ramping=0. A strobe on the first clk after reset is accepted.

Source files
------------

// File: rtl/audio_interp_dither.sv
// ----------------------------------------------------------------------------
// audio_interp_dither
//
// Audio conditioning stage that sits between the I2S clock-domain crossing
// and fm_modulator, running entirely in the clk domain. Each new sample is
// linearly interpolated over 2^R clk cycles, so that the FM deviation does not
// see staircase steps. Optional LFSR dither, scaled by dith_fact, is then
// added before the value is rounded half-up and saturated back to A bits.
//
// Parameters
//   A     audio width (two's complement, input and output)
//   R     log2 of the ramp length in clk cycles
//   SEED  LFSR reset value, must be non-zero
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high, overrides every other input
//   audio_in    new signed sample, valid while audio_stb is high
//   audio_stb   one-cycle strobe marking a new sample on audio_in
//   interp_ena  1: ramp between samples, 0: step to each sample immediately
//   dith_fact   dither amplitude, 0 = off, 7 = +/-1 output LSB
//   audio_out   registered, conditioned signed audio for fm_modulator
//   clip        one-cycle pulse when saturation limited audio_out
// ----------------------------------------------------------------------------
module audio_interp_dither #(
    parameter int          A    = 8,
    parameter int          R    = 10,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [A-1:0] audio_in,
    input  logic         audio_stb,
    input  logic         interp_ena,
    input  logic [2:0]   dith_fact,
    output logic [A-1:0] audio_out,
    output logic         clip
);

    localparam int AW = A + R;
    localparam int SW = A + R + 2;

    localparam logic [R-1:0]           CNT_ONE  = R'(1);
    localparam logic [R-1:0]           CNT_LAST = '1;
    localparam logic [15:0]            TAPS     = 16'hB400;
    localparam logic signed [SW-1:0]   HALF     = SW'(2 ** (R - 1));
    localparam logic signed [SW-1:0]   OUT_MAX  = SW'((2 ** (A - 1)) - 1);
    localparam logic signed [SW-1:0]   OUT_MIN  = SW'(-(2 ** (A - 1)));

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic signed [A-1:0]   cur, cur_nxt;
    logic signed [A:0]     delta, delta_nxt;
    logic signed [AW-1:0]  acc, acc_nxt;
    logic [R-1:0]          cnt, cnt_nxt;
    logic [15:0]           lfsr, lfsr_nxt;
    logic [A-1:0]          out_nxt;
    logic                  clip_nxt;

    logic signed [AW-1:0]  cur_fix;
    logic signed [AW-1:0]  in_fix;
    logic signed [A:0]     step_diff;
    logic signed [AW-1:0]  delta_ext;
    logic signed [R:0]     dith_raw;
    logic signed [R:0]     dith;
    logic [2:0]            dith_shift;
    logic signed [SW-1:0]  sum;
    logic signed [SW-1:0]  q_full;

    // Fixed-point views of the old target and the new sample, plus the
    // per-cycle ramp increment. The difference is formed one bit wider than
    // the audio so that a full-scale swing cannot wrap.
    always_comb begin
        cur_fix   = {cur, {R{1'b0}}};
        in_fix    = {audio_in, {R{1'b0}}};
        step_diff = {audio_in[A-1], audio_in} - {cur[A-1], cur};
        delta_ext = {{(R - 1){delta[A]}}, delta};
    end

    // Interpolator next-state logic. A strobe always wins over an ongoing
    // ramp; with interpolation enabled the accumulator restarts from the old
    // target so the ramp covers exactly old -> new. Dropping interp_ena while
    // ramping snaps straight to the target.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        delta_nxt = delta;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        if (audio_stb && interp_ena) begin
            acc_nxt   = cur_fix;
            delta_nxt = step_diff;
            cur_nxt   = audio_in;
            cnt_nxt   = '0;
            state_nxt = RAMP;
        end else if (audio_stb) begin
            acc_nxt   = in_fix;
            cur_nxt   = audio_in;
            state_nxt = IDLE;
        end else if (state == RAMP) begin
            if (!interp_ena) begin
                acc_nxt   = cur_fix;
                state_nxt = IDLE;
            end else begin
                acc_nxt = acc + delta_ext;
                cnt_nxt = cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end
            end
        end
    end

    // Right-shifting Galois LFSR; it free-runs so the dither sequence does not
    // depend on audio activity.
    always_comb begin
        lfsr_nxt = lfsr >> 1;
        if (lfsr[0]) begin
            lfsr_nxt = (lfsr >> 1) ^ TAPS;
        end
    end

    // Dither is the low R+1 LFSR bits read as a signed value (+/-1 output LSB
    // at full scale), attenuated by an arithmetic shift. Adding half an LSB
    // before the floor shift gives round half-up; the two extra sum bits keep
    // the worst case (full-scale acc plus full dither) from wrapping.
    always_comb begin
        dith_raw   = lfsr[R:0];
        dith_shift = 3'd7 - dith_fact;
        dith       = '0;
        if (dith_fact != 3'd0) begin
            dith = dith_raw >>> dith_shift;
        end
        sum    = {{2{acc[AW-1]}}, acc} + {{(SW - R - 1){dith[R]}}, dith} + HALF;
        q_full = sum >>> R;
        out_nxt  = q_full[A-1:0];
        clip_nxt = 1'b0;
        if (q_full > OUT_MAX) begin
            out_nxt  = OUT_MAX[A-1:0];
            clip_nxt = 1'b1;
        end else if (q_full < OUT_MIN) begin
            out_nxt  = OUT_MIN[A-1:0];
            clip_nxt = 1'b1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            delta     <= '0;
            acc       <= '0;
            cnt       <= '0;
            lfsr      <= SEED;
            audio_out <= '0;
            clip      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            delta     <= delta_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            lfsr      <= lfsr_nxt;
            audio_out <= out_nxt;
            clip      <= clip_nxt;
        end
    end

endmodule

// File: tb/tb_audio_interp_dither.sv
// ----------------------------------------------------------------------------
// tb_audio_interp_dither
//
// Directed bench for audio_interp_dither (A=8, R=10). Expected outputs are
// queued with the cycle they are due on and compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_audio_interp_dither;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] audio_in;
    logic       audio_stb;
    logic       interp_ena;
    logic [2:0] dith_fact;
    logic [7:0] audio_out;
    logic       clip;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         at;
        logic [7:0] val;
        logic       clp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    audio_interp_dither #(.A(8), .R(10), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst        (rst),
        .audio_in   (audio_in),
        .audio_stb  (audio_stb),
        .interp_ena (interp_ena),
        .dith_fact  (dith_fact),
        .audio_out  (audio_out),
        .clip       (clip)
    );

    // 100 MHz bench clock; cyc counts rising edges so far.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every entry due on this cycle is compared against the DUT.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            assert (audio_out === e.val) else begin
                bad++;
                $error("FAIL %s audio_out cyc=%0d observed=%h expected=%h", e.tag, cyc, audio_out, e.val);
            end
            total++;
            assert (clip === e.clp) else begin
                bad++;
                $error("FAIL %s clip cyc=%0d observed=%b expected=%b", e.tag, cyc, clip, e.clp);
            end
        end
    end

    // Round half-up of (acc_fix + d) / 1024 and saturate to 8 bits.
    function automatic logic [8:0] expect_q(input int acc_fix, input int d);
        int q;
        q = (acc_fix + d + 512) >>> 10;
        if (q > 127)  return {1'b1, 8'h7F};
        if (q < -128) return {1'b1, 8'h80};
        return {1'b0, q[7:0]};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] m);
        if (m[0]) return (m >> 1) ^ 16'hB400;
        return m >> 1;
    endfunction

    task automatic push(input int at, input int acc_fix, input int d, input string tag);
        exp_t e;
        logic [8:0] r;
        r     = expect_q(acc_fix, d);
        e.at  = at;
        e.val = r[7:0];
        e.clp = r[8];
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one strobe; it is sampled on the next rising edge, and the task
    // returns on the falling edge right after it (cyc = strobe edge).
    task automatic apply_stimulus(input logic [7:0] din, input logic ena, input logic [2:0] df);
        audio_in   = din;
        interp_ena = ena;
        dith_fact  = df;
        audio_stb  = 1'b1;
        @(negedge clk);
        audio_stb  = 1'b0;
    endtask

    // Range check used by the long dither runs.
    task automatic check_output(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                                input logic [7:0] clip_val, inout int clips);
        total++;
        assert (audio_out === lo || audio_out === hi) else begin
            bad++;
            $error("FAIL %s_range cyc=%0d observed=%h expected=%h_or_%h", tag, cyc, audio_out, lo, hi);
        end
        total++;
        assert (!clip || audio_out === clip_val) else begin
            bad++;
            $error("FAIL %s_clipval cyc=%0d observed=%h expected=%h", tag, cyc, audio_out, clip_val);
        end
        if (clip) clips++;
    endtask

    initial begin
        logic [15:0]       m;
        logic signed [10:0] low;
        int                t;
        int                s;
        int                clips;

        // Reset for two clocks with a strobe present: the strobe must be ignored.
        rst        = 1'b1;
        audio_stb  = 1'b1;
        audio_in   = 8'h55;
        interp_ena = 1'b0;
        dith_fact  = 3'd0;
        push(1, 0, 0, "reset_1");
        push(2, 0, 0, "reset_2");
        step(2);
        rst       = 1'b0;
        audio_stb = 1'b0;
        dith_fact = 3'd7;

        // Full dither around zero from the seed: exact LFSR sequence check.
        m = 16'hACE1;
        for (int j = 3; j <= 66; j++) begin
            low = m[10:0];
            push(j, 0, int'(low), "lfsr_seq");
            m = lfsr_step(m);
        end
        step(64);
        dith_fact = 3'd0;

        // Direct step: output follows two clocks after the strobe.
        $display("[TB] direct step to 0x40");
        push(cyc + 1, 0, 0, "step_old");
        apply_stimulus(8'h40, 1'b0, 3'd0);
        t = cyc;
        for (int k = 1; k <= 6; k++) push(t + k, 64 * 1024, 0, "step_new");
        step(6);

        // Ramp 0 -> 0x40 with every output cycle checked.
        $display("[TB] ramp 0x00 -> 0x40");
        apply_stimulus(8'h00, 1'b0, 3'd0);
        step(1);
        apply_stimulus(8'h40, 1'b1, 3'd0);
        t = cyc;
        for (int mm = 1; mm <= 1030; mm++) begin
            push(t + mm, 64 * ((mm - 1 <= 1024) ? (mm - 1) : 1024), 0,
                 (mm == 513) ? "ramp_mid" : ((mm == 1025) ? "ramp_end" : "ramp_up"));
        end
        step(1030);

        // Ramp 0 -> 0x40 interrupted at cnt=300 by 0xC0.
        $display("[TB] mid-ramp restrobe");
        apply_stimulus(8'h00, 1'b0, 3'd0);
        step(1);
        apply_stimulus(8'h40, 1'b1, 3'd0);
        t = cyc;
        for (int mm = 1; mm <= 301; mm++) push(t + mm, 64 * (mm - 1), 0, "pre_snap");
        step(300);
        apply_stimulus(8'hC0, 1'b1, 3'd0);
        s = cyc;
        for (int mm = 1; mm <= 1030; mm++) begin
            push(s + mm, 65536 - 128 * ((mm - 1 <= 1024) ? (mm - 1) : 1024), 0,
                 (mm == 1) ? "snap" : "ramp_down");
        end
        step(1030);

        // interp_ena dropped mid-ramp: snap to the target on the next clock.
        $display("[TB] interp_ena drop");
        apply_stimulus(8'h00, 1'b1, 3'd0);
        t = cyc;
        for (int mm = 1; mm <= 101; mm++) push(t + mm, -65536 + 64 * (mm - 1), 0, "ena_ramp");
        step(100);
        interp_ena = 1'b0;
        for (int mm = 102; mm <= 110; mm++) push(t + mm, 0, 0, "ena_snap");
        step(10);

        // Full dither at positive full scale: never wraps, clips at 0x7F.
        $display("[TB] dither at +full scale");
        apply_stimulus(8'h7F, 1'b0, 3'd7);
        step(2);
        clips = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            check_output("hi", 8'h7E, 8'h7F, 8'h7F, clips);
        end
        total++;
        assert (clips > 0) else begin
            bad++;
            $error("FAIL hi_pulses observed=%0d expected=nonzero", clips);
        end

        // Same at negative full scale: stays within 0x80..0x81, clips at 0x80.
        $display("[TB] dither at -full scale");
        apply_stimulus(8'h80, 1'b0, 3'd7);
        step(2);
        clips = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            check_output("lo", 8'h80, 8'h81, 8'h80, clips);
        end
        total++;
        assert (clips > 0) else begin
            bad++;
            $error("FAIL lo_pulses observed=%0d expected=nonzero", clips);
        end

        // Reset in the middle of a ramp, then a strobe right after reset.
        $display("[TB] reset mid-ramp");
        apply_stimulus(8'h00, 1'b0, 3'd0);
        step(1);
        apply_stimulus(8'h60, 1'b1, 3'd0);
        step(50);
        push(cyc + 1, 0, 0, "midreset");
        rst       = 1'b1;
        audio_stb = 1'b1;
        audio_in  = 8'h11;
        @(negedge clk);
        rst = 1'b0;
        audio_in   = 8'h33;
        interp_ena = 1'b0;
        t = cyc;
        push(t + 1, 0, 0, "post_reset");
        for (int k = 2; k <= 6; k++) push(t + k, 51 * 1024, 0, "first_stb");
        @(negedge clk);
        audio_stb = 1'b0;
        step(6);

        // Reset with nothing pending: output stays at zero.
        rst = 1'b1;
        interp_ena = 1'b1;
        push(cyc + 1, 0, 0, "idle_reset");
        @(negedge clk);
        rst = 1'b0;
        t = cyc;
        for (int k = 1; k <= 5; k++) push(t + k, 0, 0, "idle_hold");
        step(5);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
